exec_monitor: RTL and testbench

Run-control and end-of-program monitor sitting directly downstream of the pipeline top. It starts a program run on `valid`, and watches the fetched instruction stream for the HALT opcode. After a fixed pipeline-drain interval it asserts `done`, which drives the pipeline's `opr_finished` input. At that point it freezes a snapshot of the instruction-class counters, stall counters and final PC for the testbench and report logic.

---
 rtl/exec_monitor_pkg.sv | 17 +
 rtl/exec_monitor.sv | 134 +++++++++++++
 tb/tb_exec_monitor.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_monitor_pkg.sv
// rtl/exec_monitor_pkg.sv - shared types and constants for the run-control monitor
package exec_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } mon_state_t;

   localparam logic [5:0] OP_HALT = 6'h11;

   function automatic logic [31:0] sat_sub32(input logic [31:0] a, input logic [31:0] b);
      return (a >= b) ? (a - b) : 32'd0;
   endfunction

endpackage

// File: rtl/exec_monitor.sv
// rtl/exec_monitor.sv - run control, HALT detection, drain timing and end-of-run snapshot
module exec_monitor
   import exec_monitor_pkg::*;
#(
   parameter logic [5:0]  HALT_OPCODE  = OP_HALT,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter logic [31:0] TIMEOUT      = 32'd1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic [31:0] inst_in,
   input  logic [31:0] pc_in,
   input  logic [15:0] arith_cnt,
   input  logic [15:0] logic_cnt,
   input  logic [15:0] mem_cnt,
   input  logic [15:0] ctrl_cnt,
   input  logic [31:0] stall_wo_in,
   input  logic [31:0] stall_w_in,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic [31:0] cycle_cnt,
   output logic [31:0] halt_pc,
   output logic [17:0] total_inst,
   output logic [15:0] arith_snap,
   output logic [15:0] logic_snap,
   output logic [15:0] mem_snap,
   output logic [15:0] ctrl_snap,
   output logic [31:0] stall_saved
);

   localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

   mon_state_t state;
   mon_state_t state_nxt;
   logic [3:0] drain_cnt;
   logic       is_halt;
   logic       tmo_hit;
   logic       drain_end;
   logic       enter_done;

   assign is_halt    = (inst_in[31:26] == HALT_OPCODE);
   assign tmo_hit    = (cycle_cnt == (TIMEOUT - 32'd1));
   assign drain_end  = (drain_cnt == 4'd0);
   assign enter_done = ((state == RUN) || (state == DRAIN)) && (state_nxt == DONE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Timeout outranks both HALT detection and drain completion.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (valid) state_nxt = RUN;
         RUN:     if (tmo_hit) state_nxt = DONE;
                  else if (is_halt) state_nxt = DRAIN;
         DRAIN:   if (tmo_hit || drain_end) state_nxt = DONE;
         DONE:    if (!valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN) || (state == DRAIN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout   <= 1'b0;
         cycle_cnt <= 32'd0;
         halt_pc   <= 32'd0;
         drain_cnt <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (valid) begin
                  timeout   <= 1'b0;
                  cycle_cnt <= 32'd0;
                  halt_pc   <= 32'd0;
                  drain_cnt <= 4'd0;
               end
            end
            RUN: begin
               if (tmo_hit) begin
                  timeout <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 32'd1;
                  if (is_halt) begin
                     halt_pc   <= pc_in;
                     drain_cnt <= DRAIN_INIT;
                  end
               end
            end
            DRAIN: begin
               if (tmo_hit) begin
                  timeout <= 1'b1;
               end else begin
                  cycle_cnt <= cycle_cnt + 32'd1;
                  if (!drain_end) drain_cnt <= drain_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Snapshots survive into the next run until the next DONE entry overwrites them.
   always_ff @(posedge clk) begin
      if (reset) begin
         total_inst  <= 18'd0;
         arith_snap  <= 16'd0;
         logic_snap  <= 16'd0;
         mem_snap    <= 16'd0;
         ctrl_snap   <= 16'd0;
         stall_saved <= 32'd0;
      end else if (enter_done) begin
         total_inst  <= {2'b00, arith_cnt} + {2'b00, logic_cnt}
                      + {2'b00, mem_cnt} + {2'b00, ctrl_cnt};
         arith_snap  <= arith_cnt;
         logic_snap  <= logic_cnt;
         mem_snap    <= mem_cnt;
         ctrl_snap   <= ctrl_cnt;
         stall_saved <= sat_sub32(stall_wo_in, stall_w_in);
      end
   end

endmodule

// File: tb/tb_exec_monitor.sv
// tb/tb_exec_monitor.sv - self-checking bench for exec_monitor
module tb_exec_monitor;

   localparam int unsigned DRAIN   = 4;
   localparam logic [31:0] TMO_A   = 32'd1_000_000;
   localparam logic [31:0] TMO_B   = 32'd8;
   localparam logic [31:0] INST_NOP = 32'h0400_0000;
   localparam logic [31:0] INST_HLT = 32'h4400_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        valid_a = 1'b0;
   logic        valid_b = 1'b0;
   logic [31:0] inst_in = 32'd0;
   logic [31:0] pc_in = 32'd0;
   logic [15:0] arith_cnt = 16'd0, logic_cnt = 16'd0, mem_cnt = 16'd0, ctrl_cnt = 16'd0;
   logic [31:0] stall_wo_in = 32'd0, stall_w_in = 32'd0;

   logic        busy_a, done_a, timeout_a, busy_b, done_b, timeout_b;
   logic [31:0] cycle_a, hpc_a, saved_a, cycle_b, hpc_b, saved_b;
   logic [17:0] total_a, total_b;
   logic [15:0] as_a, ls_a, ms_a, cs_a, as_b, ls_b, ms_b, cs_b;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   exec_monitor #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO_A)) u_dut_a (
      .clk(clk), .reset(reset), .valid(valid_a), .inst_in(inst_in), .pc_in(pc_in),
      .arith_cnt(arith_cnt), .logic_cnt(logic_cnt), .mem_cnt(mem_cnt), .ctrl_cnt(ctrl_cnt),
      .stall_wo_in(stall_wo_in), .stall_w_in(stall_w_in),
      .busy(busy_a), .done(done_a), .timeout(timeout_a), .cycle_cnt(cycle_a), .halt_pc(hpc_a),
      .total_inst(total_a), .arith_snap(as_a), .logic_snap(ls_a), .mem_snap(ms_a),
      .ctrl_snap(cs_a), .stall_saved(saved_a));

   exec_monitor #(.DRAIN_CYCLES(DRAIN), .TIMEOUT(TMO_B)) u_dut_b (
      .clk(clk), .reset(reset), .valid(valid_b), .inst_in(inst_in), .pc_in(pc_in),
      .arith_cnt(arith_cnt), .logic_cnt(logic_cnt), .mem_cnt(mem_cnt), .ctrl_cnt(ctrl_cnt),
      .stall_wo_in(stall_wo_in), .stall_w_in(stall_w_in),
      .busy(busy_b), .done(done_b), .timeout(timeout_b), .cycle_cnt(cycle_b), .halt_pc(hpc_b),
      .total_inst(total_b), .arith_snap(as_b), .logic_snap(ls_b), .mem_snap(ms_b),
      .ctrl_snap(cs_b), .stall_saved(saved_b));

   always #5 clk = ~clk;

   // Run model: counts edges of an active run; the run ends when the edge count
   // reaches the timeout limit or the HALT edge index plus the drain length.
   typedef struct packed {
      logic        active;
      logic        fin;
      logic        to;
      logic [31:0] edges;
      logic        halt_seen;
      logic [31:0] halt_at;
      logic [31:0] hpc;
      logic [17:0] total;
      logic [15:0] a, l, m, c;
      logic [31:0] saved;
   } mdl_t;

   mdl_t ma = '0;
   mdl_t mb = '0;

   function automatic mdl_t finish_run(input mdl_t m);
      int     sum;
      longint wo, w;
      mdl_t   r = m;
      sum = int'(arith_cnt) + int'(logic_cnt) + int'(mem_cnt) + int'(ctrl_cnt);
      wo  = longint'(stall_wo_in);
      w   = longint'(stall_w_in);
      r.active = 1'b0;
      r.fin    = 1'b1;
      r.total  = sum[17:0];
      r.a = arith_cnt; r.l = logic_cnt; r.m = mem_cnt; r.c = ctrl_cnt;
      r.saved  = (wo >= w) ? 32'(wo - w) : 32'd0;
      return r;
   endfunction

   function automatic mdl_t step(input mdl_t m, input logic rst, input logic v, input logic [31:0] tmo);
      mdl_t r = m;
      logic [31:0] n;
      if (rst) begin
         r = '0;
      end else if (m.active) begin
         n = m.edges + 32'd1;
         if (n == tmo) begin
            r = finish_run(m);
            r.to = 1'b1;
         end else begin
            r.edges = n;
            if (!m.halt_seen && inst_in[31:26] == 6'h11) begin
               r.halt_seen = 1'b1;
               r.halt_at   = n;
               r.hpc       = pc_in;
            end else if (m.halt_seen && n == m.halt_at + DRAIN) begin
               r = finish_run(r);
            end
         end
      end else if (m.fin) begin
         if (!v) r.fin = 1'b0;
      end else if (v) begin
         r.active = 1'b1; r.edges = '0; r.halt_seen = 1'b0; r.halt_at = '0;
         r.hpc = '0; r.to = 1'b0;
      end
      return r;
   endfunction

   always @(posedge clk) begin
      ma <= step(ma, reset, valid_a, TMO_A);
      mb <= step(mb, reset, valid_b, TMO_B);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_unit(input string t, input mdl_t m, input logic b, input logic d,
                           input logic to, input logic [31:0] cyc, input logic [31:0] hpc,
                           input logic [17:0] tot, input logic [15:0] a, input logic [15:0] l,
                           input logic [15:0] me, input logic [15:0] c, input logic [31:0] sv);
      chk({t, ".busy"}, 64'(b), 64'(m.active));
      chk({t, ".done"}, 64'(d), 64'(m.fin));
      chk({t, ".timeout"}, 64'(to), 64'(m.to));
      chk({t, ".cycle_cnt"}, 64'(cyc), 64'(m.edges));
      chk({t, ".halt_pc"}, 64'(hpc), 64'(m.hpc));
      chk({t, ".total_inst"}, 64'(tot), 64'(m.total));
      chk({t, ".arith_snap"}, 64'(a), 64'(m.a));
      chk({t, ".logic_snap"}, 64'(l), 64'(m.l));
      chk({t, ".mem_snap"}, 64'(me), 64'(m.m));
      chk({t, ".ctrl_snap"}, 64'(c), 64'(m.c));
      chk({t, ".stall_saved"}, 64'(sv), 64'(m.saved));
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         cmp_unit("a", ma, busy_a, done_a, timeout_a, cycle_a, hpc_a, total_a,
                  as_a, ls_a, ms_a, cs_a, saved_a);
         cmp_unit("b", mb, busy_b, done_b, timeout_b, cycle_b, hpc_b, total_b,
                  as_b, ls_b, ms_b, cs_b, saved_b);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int n;

   initial begin
      tick();
      cmp_en = 1'b1;
      tick();
      reset = 1'b0;
      chk("reset_busy", 64'(busy_a), 64'd0);
      chk("reset_done", 64'(done_a), 64'd0);
      chk("reset_total", 64'(total_a), 64'd0);
      chk("reset_saved", 64'(saved_a), 64'd0);

      // reset on the second drain cycle aborts the run
      valid_a = 1'b1; inst_in = INST_NOP;
      tick(); tick(); tick();
      inst_in = INST_HLT; pc_in = 32'h20;
      tick();
      inst_in = INST_NOP;
      tick();
      chk("mid_drain_busy", 64'(busy_a), 64'd1);
      reset = 1'b1; valid_a = 1'b0;
      tick();
      reset = 1'b0;
      chk("abort_busy", 64'(busy_a), 64'd0);
      chk("abort_cycle", 64'(cycle_a), 64'd0);
      chk("abort_hpc", 64'(hpc_a), 64'd0);
      tick(); tick(); tick(); tick();
      chk("abort_no_done", 64'(done_a), 64'd0);

      // HALT on the 10th RUN cycle at pc 0x40
      valid_a = 1'b1;
      tick();
      for (int i = 1; i <= 9; i++) begin
         inst_in = {6'h23, 26'(i)}; pc_in = 32'(i * 4);
         tick();
      end
      inst_in = INST_HLT; pc_in = 32'h40;
      arith_cnt = 16'd100; logic_cnt = 16'd50; mem_cnt = 16'd30; ctrl_cnt = 16'd20;
      stall_wo_in = 32'd25; stall_w_in = 32'd10;
      tick();
      inst_in = INST_NOP; pc_in = 32'h44;
      n = 0;
      while (!done_a && n < 20) begin tick(); n++; end
      chk("halt_to_done_edges", 64'(n), 64'd4);
      chk("halt_pc_40", 64'(hpc_a), 64'h40);
      chk("cycle_cnt_14", 64'(cycle_a), 64'd14);
      chk("total_200", 64'(total_a), 64'd200);
      chk("saved_15", 64'(saved_a), 64'd15);
      arith_cnt = 16'd7; stall_wo_in = 32'd99; pc_in = 32'h100; inst_in = INST_HLT;
      tick(); tick(); tick();
      chk("hold_done", 64'(done_a), 64'd1);
      chk("hold_total", 64'(total_a), 64'd200);
      chk("hold_saved", 64'(saved_a), 64'd15);
      chk("hold_cycle", 64'(cycle_a), 64'd14);
      valid_a = 1'b0; inst_in = INST_NOP;
      tick();
      chk("back_idle", 64'(done_a), 64'd0);

      // saturation, floored stall difference and a 3-cycle fetch-stalled HALT
      valid_a = 1'b1;
      tick();
      tick(); tick();
      arith_cnt = 16'hFFFF; logic_cnt = 16'hFFFF; mem_cnt = 16'hFFFF; ctrl_cnt = 16'hFFFF;
      stall_wo_in = 32'd20; stall_w_in = 32'd30;
      inst_in = INST_HLT; pc_in = 32'h80; tick();
      pc_in = 32'h84; tick();
      pc_in = 32'h88; tick();
      inst_in = INST_NOP; pc_in = 32'h8C;
      n = 2;
      while (!done_a && n < 20) begin tick(); n++; end
      chk("stall_halt_done_edges", 64'(n), 64'd4);
      chk("halt_pc_first", 64'(hpc_a), 64'h80);
      chk("cycle_cnt_7", 64'(cycle_a), 64'd7);
      chk("total_3fffc", 64'(total_a), 64'h3FFFC);
      chk("saved_floor", 64'(saved_a), 64'd0);
      valid_a = 1'b0;
      tick();

      // timeout run on the TIMEOUT=8 instance
      valid_b = 1'b1;
      tick();
      n = 0;
      while (!done_b && n < 20) begin tick(); n++; end
      chk("timeout_run_edges", 64'(n), 64'd8);
      chk("timeout_flag", 64'(timeout_b), 64'd1);
      chk("timeout_cycle_7", 64'(cycle_b), 64'd7);
      chk("timeout_total", 64'(total_b), 64'h3FFFC);
      valid_b = 1'b0;
      tick();
      chk("timeout_idle", 64'(done_b), 64'd0);
      valid_b = 1'b1;
      tick();
      chk("restart_busy", 64'(busy_b), 64'd1);
      chk("restart_cycle", 64'(cycle_b), 64'd0);
      chk("restart_timeout", 64'(timeout_b), 64'd0);
      tick();
      chk("restart_cycle_1", 64'(cycle_b), 64'd1);
      valid_b = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
